// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one shift-and-trial-subtract per clock,
// started by a start/done handshake. Divide by zero finishes straight away and sets a flag.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on the start edge
// RUN   | iterating, one quotient bit per clock
// DONE  | one-cycle done pulse, results valid
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] q_d;

  // Trial subtract in the adder's style: invert divisor, carry-in 1; MSB clear means no borrow.
  always_comb begin
    trial     = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff      = trial + ~{1'b0, dsr_q} + ONE;
    no_borrow = ~diff[WIDTH];
    p_d       = no_borrow ? diff : trial;
    q_d       = {q_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      q_q           <= '0;
      dsr_q         <= '0;
      cnt_q         <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            if (divisor_i != '0) begin
              state_q <= RUN;
              busy_o  <= 1'b1;
              p_q     <= '0;
              q_q     <= dividend_i;
              dsr_q   <= divisor_i;
              cnt_q   <= CW'(WIDTH - 1);
            end else begin
              state_q       <= DONE;
              done_o        <= 1'b1;
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
            end
          end
        end
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q       <= DONE;
            busy_o        <= 1'b0;
            done_o        <= 1'b1;
            quotient_o    <= q_d;
            remainder_o   <= p_d[WIDTH-1:0];
            div_by_zero_o <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
